// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_stage_pkg;

  localparam int INSN_WIDTH      = 32;
  localparam int WORD_ADDR_WIDTH = 30;

  typedef enum logic [1:0] {
    FS_REQ,
    FS_WAIT,
    FS_DROP
  } fetch_state_t;

  typedef struct packed {
    logic [WORD_ADDR_WIDTH-1:0] addr;
    logic [INSN_WIDTH-1:0]      insn;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - small circular FIFO holding fetched {addr, insn} entries
module fetch_buffer #(
  parameter int WIDTH = 62,
  parameter int DEPTH = 2,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, single-outstanding imem FSM, redirect flush
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0,
  parameter int                    BUF_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-3:0] redirect_addr,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-3:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [31:0]           imem_rsp_data,
  output logic                  insn_valid,
  output logic [ADDR_WIDTH-3:0] insn_addr,
  output logic [31:0]           insn,
  input  logic                  out_ready
);

  localparam int WA = ADDR_WIDTH - 2;
  localparam int EW = WA + INSN_WIDTH;
  localparam int CW = $clog2(BUF_DEPTH + 1);

  fetch_state_t  state;
  fetch_state_t  state_nxt;
  logic [WA-1:0] pc;
  logic [WA-1:0] req_addr;
  logic [CW-1:0] count;
  logic [EW-1:0] head;
  logic          room;
  logic          accept;
  logic          push;
  logic          pop;

  // Only REQ can hold an empty slot count, so the buffer count alone reserves the response slot.
  assign room          = count < CW'(BUF_DEPTH);
  assign accept        = imem_req_valid && imem_req_ready;
  assign imem_req_addr = pc;
  assign insn_valid    = (count != '0);
  assign pop           = insn_valid && out_ready;
  assign {insn_addr, insn} = head;

  always_comb begin
    state_nxt      = state;
    imem_req_valid = 1'b0;
    push           = 1'b0;
    case (state)
      FS_REQ: begin
        // Requests are suppressed during a redirect, so a killed accept never occurs here.
        imem_req_valid = rst && !redirect_valid && room;
        if (imem_req_valid && imem_req_ready) state_nxt = FS_WAIT;
      end
      FS_WAIT: begin
        if (imem_rsp_valid) begin
          push      = !redirect_valid;
          state_nxt = FS_REQ;
        end else if (redirect_valid) begin
          state_nxt = FS_DROP;
        end
      end
      FS_DROP: begin
        if (imem_rsp_valid) state_nxt = FS_REQ;
      end
      default: state_nxt = FS_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= FS_REQ;
      pc       <= RESET_ADDR[ADDR_WIDTH-1:2];
      req_addr <= '0;
    end else begin
      state <= state_nxt;
      if (redirect_valid) begin
        pc <= redirect_addr;
      end else if (accept) begin
        pc       <= pc + WA'(1);
        req_addr <= pc;
      end
    end
  end

  fetch_buffer #(
    .WIDTH (EW),
    .DEPTH (BUF_DEPTH)
  ) u_buffer (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({req_addr, imem_rsp_data}),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (count),
    .head      (head)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized self-checking bench for fetch_stage against a stream-level model
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam int AW = 32;
  localparam int WA = AW - 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          redirect_valid;
  logic [WA-1:0] redirect_addr;
  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [WA-1:0] imem_req_addr;
  logic          imem_rsp_valid;
  logic [31:0]   imem_rsp_data;
  logic          insn_valid;
  logic [WA-1:0] insn_addr;
  logic [31:0]   insn;
  logic          out_ready;

  always #5 clk = ~clk;

  fetch_stage #(
    .ADDR_WIDTH (AW),
    .RESET_ADDR (32'h100),
    .BUF_DEPTH  (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .insn_valid     (insn_valid),
    .insn_addr      (insn_addr),
    .insn           (insn),
    .out_ready      (out_ready)
  );

  int checks = 0;
  int errors = 0;

  // Model of the fetch->decode stream: next address to fetch / deliver, live or killed request, queue depth.
  logic [WA-1:0] exp_fetch;
  logic [WA-1:0] exp_deliver;
  bit            m_out;
  bit            m_kill;
  int            m_buf;

  // Instruction memory: one pending response with a random delay.
  bit            pend = 1'b0;
  fetch_entry_t  pend_e = '0;
  int            pend_cnt = 0;

  int            p_ready = 100;
  int            p_out = 100;
  int            max_dly = 0;
  int            cyc;
  int            first_acc;
  int            first_val;
  bit            last_acc;
  logic [WA-1:0] last_acc_addr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [WA-1:0] a);
    return ({2'b00, a} * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic model_reset();
    exp_fetch   = 30'h40;
    exp_deliver = 30'h40;
    m_out       = 1'b0;
    m_kill      = 1'b0;
    m_buf       = 0;
    cyc         = 0;
    first_acc   = -1;
    first_val   = -1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst            = 1'b0;
    redirect_valid = 1'b0;
    imem_req_ready = 1'($urandom_range(1));
    out_ready      = 1'($urandom_range(1));
    imem_rsp_valid = pend;
    imem_rsp_data  = pend_e.insn;
    pend           = 1'b0;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b1;
    redirect_addr  = 30'($urandom);
    #1;
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_insn_valid", insn_valid, 0);
    check("rst_insn_addr", insn_addr, 0);
    check("rst_insn", insn, 0);
    @(negedge clk);
    rst            = 1'b1;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b0;
    out_ready      = 1'b0;
    model_reset();
  endtask

  task automatic step(input bit redir, input logic [WA-1:0] tgt);
    bit acc;
    bit pop;
    bit rsp;
    bit exp_rv;
    @(negedge clk);
    redirect_valid = redir;
    redirect_addr  = tgt;
    imem_req_ready = (int'($urandom_range(99)) < p_ready);
    out_ready      = (int'($urandom_range(99)) < p_out);
    rsp            = pend && (pend_cnt == 0);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? pend_e.insn : $urandom;
    #1;
    acc    = imem_req_valid && imem_req_ready;
    pop    = insn_valid && out_ready;
    exp_rv = !redir && !m_out && !m_kill && (m_buf < 2);
    check("req_valid", imem_req_valid, exp_rv);
    if (imem_req_valid) check("req_addr", imem_req_addr, exp_fetch);
    check("insn_valid", insn_valid, m_buf > 0);
    if (insn_valid) begin
      check("insn_addr", insn_addr, exp_deliver);
      check("insn_data", insn, mem_word(exp_deliver));
    end
    if (acc) check("single_outstanding", pend, 0);
    last_acc      = acc;
    last_acc_addr = imem_req_addr;
    if (acc && first_acc < 0) first_acc = cyc;
    if (insn_valid && first_val < 0) first_val = cyc;

    if (redir) begin
      exp_fetch   = tgt;
      exp_deliver = tgt;
      m_buf       = 0;
      if (m_kill && rsp) m_kill = 1'b0;
      if (m_out && !rsp) m_kill = 1'b1;
      m_out = 1'b0;
    end else begin
      if (pop) begin
        m_buf--;
        exp_deliver = exp_deliver + 1'b1;
      end
      if (rsp) begin
        if (m_out) m_buf++;
        m_out  = 1'b0;
        m_kill = 1'b0;
      end
      if (acc) begin
        m_out     = 1'b1;
        exp_fetch = exp_fetch + 1'b1;
      end
    end

    if (rsp) pend = 1'b0;
    else if (pend) pend_cnt--;
    if (acc) begin
      pend        = 1'b1;
      pend_e.addr = imem_req_addr;
      pend_e.insn = mem_word(imem_req_addr);
      pend_cnt    = int'($urandom_range(max_dly));
    end
    cyc++;
    @(posedge clk);
  endtask

  task automatic next_accept(input string tag, input logic [WA-1:0] exp);
    int n = 0;
    do begin
      step(1'b0, '0);
      n++;
    end while (!last_acc && n < 50);
    check({tag, "_seen"}, last_acc, 1);
    check(tag, last_acc_addr, exp);
  endtask

  initial begin
    int n;
    rst            = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    out_ready      = 1'b0;
    model_reset();

    // In-order delivery from 'h40 and the 2-cycle accept-to-output latency.
    do_reset();
    p_ready = 100; p_out = 100; max_dly = 0;
    repeat (12) step(1'b0, '0);
    check("latency", 64'(first_val - first_acc), 2);

    // Decode stalls: buffer fills, requests stop, head holds.
    do_reset();
    p_out = 0;
    repeat (10) step(1'b0, '0);
    #1;
    check("hold_head", insn_addr, 30'h40);
    check("hold_valid", insn_valid, 1);
    check("hold_req_valid", imem_req_valid, 0);

    // Redirect while a request is in flight: its response is dropped.
    p_out = 100; max_dly = 2;
    n = 0;
    while (!(m_out && pend_cnt > 0) && n < 50) begin
      step(1'b0, '0);
      n++;
    end
    check("wait_found", m_out && pend_cnt > 0, 1);
    step(1'b1, 30'h80);
    next_accept("redir_wait_addr", 30'h80);
    repeat (8) step(1'b0, '0);

    // Redirect coincident with a response while the buffer holds an entry.
    do_reset();
    p_out = 0; max_dly = 0;
    n = 0;
    while (!(m_buf == 1 && m_out && pend && pend_cnt == 0) && n < 50) begin
      step(1'b0, '0);
      n++;
    end
    check("rsp_redir_found", m_buf == 1 && m_out, 1);
    step(1'b1, 30'h123);
    #1;
    check("flush_empty", insn_valid, 0);
    p_out = 100;
    next_accept("redir_rsp_addr", 30'h123);

    // PC wrap at the top of the address space.
    step(1'b1, 30'h3FFF_FFFF);
    next_accept("wrap_top", 30'h3FFF_FFFF);
    next_accept("wrap_zero", 30'h0);
    repeat (6) step(1'b0, '0);

    // imem back-pressure: address held, nothing produced.
    do_reset();
    p_ready = 0;
    repeat (5) step(1'b0, '0);
    #1;
    check("stall_addr", imem_req_addr, 30'h40);
    check("stall_no_insn", insn_valid, 0);

    // Randomized traffic with redirects and a mid-run reset.
    for (int blk = 0; blk < 16; blk++) begin
      p_ready = int'($urandom_range(30, 100));
      p_out   = int'($urandom_range(20, 100));
      max_dly = int'($urandom_range(0, 3));
      if (blk == 8) do_reset();
      for (int i = 0; i < 200; i++) begin
        if ($urandom_range(99) < 4)
          step(1'b1, ($urandom_range(3) == 0) ? 30'h3FFF_FFFE : 30'($urandom));
        else
          step(1'b0, '0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
